mem_port_arbiter: RTL

- Shares one single-port synchronous memory (1-cycle read latency, 4 byte-lane write enables) between the core's instruction-fetch port and data (load/store) port.
- Requests from both ports are handled as req/ready transactions. Simultaneous requests are resolved round-robin.
- Sits between the MIPS core (PC/instr and aluresult/writedata/memwrite/readdata) and the unified memory. The core stalls while its port's ready is low.

---
 rtl/mem_port_arbiter.sv | 109 ++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_port_arbiter: round-robin I/D sharing of one 1-cycle sync memory.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_port_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req,
  input  logic [ADDR_W-1:0]     i_addr,
  output logic                  i_ready,
  output logic [DATA_W-1:0]     i_rdata,
  input  logic                  d_req,
  input  logic [DATA_W/8-1:0]   d_we,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic                  d_ready,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  m_en,
  output logic [DATA_W/8-1:0]   m_we,
  output logic [ADDR_W-3:0]     m_addr,
  output logic [DATA_W-1:0]     m_wdata,
  input  logic [DATA_W-1:0]     m_rdata,
  output logic [CNT_W-1:0]      conflict_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IRESP = 2'd1,
    DRESP = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_last_d;
  logic             r_i_ready;
  logic             r_d_ready;
  logic [CNT_W-1:0] r_cnt;

  logic w_i_elig;
  logic w_d_elig;
  logic w_grant_i;
  logic w_grant_d;
  logic w_conflict;
  logic w_unused_addr_lsbs;

  // A port in its response cycle is about to drop req, so it must not be re-issued.
  assign w_i_elig   = rst_n & i_req & (r_state != IRESP);
  assign w_d_elig   = rst_n & d_req & (r_state != DRESP);
  assign w_grant_i  = w_i_elig & (~w_d_elig | r_last_d);
  assign w_grant_d  = w_d_elig & (~w_i_elig | ~r_last_d);
  assign w_conflict = (w_i_elig & ~w_grant_i) | (w_d_elig & ~w_grant_d);

  assign w_unused_addr_lsbs = ^{i_addr[1:0], d_addr[1:0]};

  always_comb begin
    m_en    = w_grant_i | w_grant_d;
    m_we    = '0;
    m_addr  = '0;
    m_wdata = '0;
    if (w_grant_i) begin
      m_addr = i_addr[ADDR_W-1:2];
    end else if (w_grant_d) begin
      m_addr  = d_addr[ADDR_W-1:2];
      m_we    = d_we;
      m_wdata = d_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_last_d  <= 1'b1;
      r_i_ready <= 1'b0;
      r_d_ready <= 1'b0;
      r_cnt     <= '0;
    end else begin
      if (w_grant_i) begin
        r_state   <= IRESP;
        r_last_d  <= 1'b0;
        r_i_ready <= 1'b1;
        r_d_ready <= 1'b0;
      end else if (w_grant_d) begin
        r_state   <= DRESP;
        r_last_d  <= 1'b1;
        r_i_ready <= 1'b0;
        r_d_ready <= 1'b1;
      end else begin
        r_state   <= IDLE;
        r_i_ready <= 1'b0;
        r_d_ready <= 1'b0;
      end
      if (w_conflict && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign i_ready      = r_i_ready;
  assign d_ready      = r_d_ready;
  assign i_rdata      = r_i_ready ? m_rdata : '0;
  assign d_rdata      = r_d_ready ? m_rdata : '0;
  assign conflict_cnt = r_cnt;

endmodule
`default_nettype wire
